// File: rtl/cmd_pkg.sv
// Shared types for the command executor: opcodes, FSM state codes, operand-count
// requirements and the packed result record.
package cmd_pkg;

   localparam int RES_W = 8;

   typedef enum logic [7:0] {
      OP_NOP = 8'h00,
      OP_ADD = 8'h01,
      OP_SUB = 8'h02,
      OP_AND = 8'h03,
      OP_OR  = 8'h04,
      OP_XOR = 8'h05,
      OP_SHL = 8'h06,
      OP_SHR = 8'h07,
      OP_MUL = 8'h08
   } op_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_MUL  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [1:0] NEED_NOP = 2'd1;
   localparam logic [1:0] NEED_ALU = 2'd3;

   typedef struct packed {
      logic [RES_W-1:0] data;
      logic             zero;
      logic             carry;
      logic             err;
   } res_t;

endpackage

// File: rtl/cmd_exec_if.sv
// Command-in / result-out handshake bundle; master drives commands, slave executes them.
interface cmd_exec_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_op;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [1:0]        in_cnt;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_zero;
   logic              out_carry;
   logic              out_err;
   logic [CNT_W-1:0]  cmd_count;

   modport master (
      output in_valid, in_op, in_a, in_b, in_cnt, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_carry, out_err, cmd_count
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_cnt, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_carry, out_err, cmd_count
   );
endinterface

// File: rtl/cmd_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, done pulses DATA_W cycles
// after start with the full 2*DATA_W product; start is ignored while busy.
module cmd_mul_seq #(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   output logic                busy,
   output logic                done,
   output logic [2*DATA_W-1:0] prod
);
   localparam int CW = $clog2(DATA_W + 1);

   logic [2*DATA_W-1:0] mcand;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   mplier;
   logic [CW-1:0]       cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
         end else if (busy) begin
            if (mplier[0])
               acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            // Last partial product lands together with the done pulse.
            if (cnt == CW'(DATA_W - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign prod = acc;

endmodule

// File: rtl/cmd_exec.sv
// Executes one command bundle at a time; ALU ops present a result one cycle after accept,
// MUL (only with CMD_EXEC_MUL_EN) after 1+DATA_W; the result is held until out_ready.
module cmd_exec
   import cmd_pkg::*;
#(
   parameter int DATA_W = RES_W,
   parameter int CNT_W  = 16
) (
   input logic       clk,
   input logic       rst_n,
   cmd_exec_if.slave bus
);
   logic [1:0]        state;
   logic [7:0]        op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [1:0]        cnt_q;
   logic [CNT_W-1:0]  count_q;
   res_t              res_q;
   res_t              alu_res;
   logic              legal;
   logic [2:0]        sh;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W:0]   ext_l;
   logic [DATA_W:0]   ext_r;

   always_comb begin
      alu_res = '0;
      legal   = 1'b0;
      sh      = b_q[2:0];
      sum     = {1'b0, a_q} + {1'b0, b_q};
      diff    = {1'b0, a_q} - {1'b0, b_q};
      // Shift through one spare bit so the last bit shifted out is the carry.
      ext_l   = {1'b0, a_q} << sh;
      ext_r   = {a_q, 1'b0} >> sh;
      case (op_q)
         OP_NOP: legal = (cnt_q >= NEED_NOP);
         OP_ADD: begin
            legal         = (cnt_q == NEED_ALU);
            alu_res.data  = sum[DATA_W-1:0];
            alu_res.carry = sum[DATA_W];
         end
         OP_SUB: begin
            legal         = (cnt_q == NEED_ALU);
            alu_res.data  = diff[DATA_W-1:0];
            alu_res.carry = diff[DATA_W];
         end
         OP_AND: begin
            legal        = (cnt_q == NEED_ALU);
            alu_res.data = a_q & b_q;
         end
         OP_OR: begin
            legal        = (cnt_q == NEED_ALU);
            alu_res.data = a_q | b_q;
         end
         OP_XOR: begin
            legal        = (cnt_q == NEED_ALU);
            alu_res.data = a_q ^ b_q;
         end
         OP_SHL: begin
            legal         = (cnt_q == NEED_ALU);
            alu_res.data  = ext_l[DATA_W-1:0];
            alu_res.carry = ext_l[DATA_W];
         end
         OP_SHR: begin
            legal         = (cnt_q == NEED_ALU);
            alu_res.data  = ext_r[DATA_W:1];
            alu_res.carry = ext_r[0];
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         alu_res.data  = '0;
         alu_res.carry = 1'b0;
         alu_res.err   = 1'b1;
      end
      alu_res.zero = (alu_res.data == '0);
   end

`ifdef CMD_EXEC_MUL_EN
   logic                mul_go;
   logic                mul_busy;
   logic                mul_done;
   logic [2*DATA_W-1:0] mul_prod;

   assign mul_go = (state == ST_IDLE) && bus.in_valid &&
                   (bus.in_op == OP_MUL) && (bus.in_cnt == NEED_ALU);

   cmd_mul_seq #(.DATA_W(DATA_W)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_go),
      .a     (bus.in_a),
      .b     (bus.in_b),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (mul_prod)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         count_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (bus.in_valid) begin
               op_q  <= bus.in_op;
               a_q   <= bus.in_a;
               b_q   <= bus.in_b;
               cnt_q <= bus.in_cnt;
`ifdef CMD_EXEC_MUL_EN
               state <= mul_go ? ST_MUL : ST_EXEC;
`else
               state <= ST_EXEC;
`endif
            end
            ST_EXEC: begin
               res_q <= alu_res;
               state <= ST_DONE;
            end
`ifdef CMD_EXEC_MUL_EN
            ST_MUL: if (mul_done) begin
               res_q.data  <= mul_prod[DATA_W-1:0];
               res_q.zero  <= (mul_prod[DATA_W-1:0] == '0);
               res_q.carry <= |mul_prod[2*DATA_W-1:DATA_W];
               res_q.err   <= 1'b0;
               state       <= ST_DONE;
            end else if (!mul_busy) begin
               // Multiplier idle without a done pulse: never expected, recover to IDLE.
               state <= ST_IDLE;
            end
`endif
            ST_DONE: if (bus.out_ready) begin
               state <= ST_IDLE;
               if (count_q != '1)
                  count_q <= count_q + CNT_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);
   assign bus.out_data  = res_q.data;
   assign bus.out_zero  = res_q.zero;
   assign bus.out_carry = res_q.carry;
   assign bus.out_err   = res_q.err;
   assign bus.cmd_count = count_q;

endmodule

// File: tb/tb_cmd_exec.sv
// Directed self-checking bench for cmd_exec; MUL expectations follow CMD_EXEC_MUL_EN.
module tb_cmd_exec;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   cmd_exec_if #(.DATA_W(8), .CNT_W(16)) bus ();

   cmd_exec #(.DATA_W(8), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] cnt;
      logic [7:0] data;
      logic       carry;
      logic       err;
   } vec_t;

   // Present one bundle, accept it, scramble the inputs, count edges until out_valid.
   task automatic do_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] cnt, output int lat);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cnt   = cnt;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_op    = 8'h05;
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      bus.in_cnt   = 2'd3;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_zero, bus.out_carry, bus.out_err} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h z=%b c=%b e=%b, expected rdy=1 vld=0 data=00 z=0 c=0 e=0",
                  bus.in_ready, bus.out_valid, bus.out_data, bus.out_zero, bus.out_carry, bus.out_err);
      end
      checks++;
      if (bus.cmd_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", bus.cmd_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_add();
      int lat;
      do_cmd(8'h01, 8'hF0, 8'h20, 2'd3, lat);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL add_latency: got %0d expected 1", lat);
      end
      checks++;
      if ({bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {8'h10, 3'b100}) begin
         errors++;
         $display("FAIL add_result: got data=%h c=%b z=%b e=%b expected data=10 c=1 z=0 e=0",
                  bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL add_busy_ready: got %b expected 0", bus.in_ready);
      end
      take();
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.cmd_count} !== {1'b0, 1'b1, 16'd1}) begin
         errors++;
         $display("FAIL add_handshake: got vld=%b rdy=%b count=%0d expected vld=0 rdy=1 count=1",
                  bus.out_valid, bus.in_ready, bus.cmd_count);
      end
   endtask

   task automatic test_sub_backpressure();
      int lat;
      int bad;
      do_cmd(8'h02, 8'h05, 8'h05, 2'd3, lat);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_zero, bus.out_carry, bus.out_err} !== {1'b1, 1'b0, 8'h00, 3'b100})
            bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad !== 0 || lat !== 1) begin
         errors++;
         $display("FAIL sub_hold: got %0d unstable cycles latency %0d data=%h z=%b expected 0 unstable latency 1 data=00 z=1",
                  bad, lat, bus.out_data, bus.out_zero);
      end
      take();
      checks++;
      if (bus.cmd_count !== 16'd2) begin
         errors++;
         $display("FAIL sub_count: got %0d expected 2", bus.cmd_count);
      end
   endtask

   task automatic test_alu_ops();
      vec_t tab [0:8];
      int   lat;
      logic [10:0] exp_v;
      tab[0] = '{8'h03, 8'hF0, 8'h3C, 2'd3, 8'h30, 1'b0, 1'b0};
      tab[1] = '{8'h04, 8'hF0, 8'h0F, 2'd3, 8'hFF, 1'b0, 1'b0};
      tab[2] = '{8'h05, 8'hAA, 8'hFF, 2'd3, 8'h55, 1'b0, 1'b0};
      tab[3] = '{8'h06, 8'h81, 8'h01, 2'd3, 8'h02, 1'b1, 1'b0};
      tab[4] = '{8'h06, 8'h81, 8'hF8, 2'd3, 8'h81, 1'b0, 1'b0};
      tab[5] = '{8'h07, 8'h81, 8'h01, 2'd3, 8'h40, 1'b1, 1'b0};
      tab[6] = '{8'h07, 8'h80, 8'h07, 2'd3, 8'h01, 1'b0, 1'b0};
      tab[7] = '{8'h02, 8'h03, 8'h05, 2'd3, 8'hFE, 1'b1, 1'b0};
      tab[8] = '{8'h01, 8'hFF, 8'h01, 2'd3, 8'h00, 1'b1, 1'b0};
      for (int i = 0; i < 9; i++) begin
         do_cmd(tab[i].op, tab[i].a, tab[i].b, tab[i].cnt, lat);
         exp_v = {tab[i].data, tab[i].carry, (tab[i].data == 8'h00), tab[i].err};
         checks++;
         if (lat !== 1 || {bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== exp_v) begin
            errors++;
            $display("FAIL alu_vec%0d op=%h: got lat=%0d data/c/z/e=%h expected lat=1 data/c/z/e=%h",
                     i, tab[i].op, lat, {bus.out_data, bus.out_carry, bus.out_zero, bus.out_err}, exp_v);
         end
         take();
      end
      checks++;
      if (bus.cmd_count !== 16'd11) begin
         errors++;
         $display("FAIL alu_count: got %0d expected 11", bus.cmd_count);
      end
   endtask

   task automatic test_errors();
      int lat;
      do_cmd(8'h3F, 8'h12, 8'h34, 2'd3, lat);
      checks++;
      if ({bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {8'h00, 3'b011}) begin
         errors++;
         $display("FAIL err_bad_op: got data=%h c=%b z=%b e=%b expected data=00 c=0 z=1 e=1",
                  bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
      end
      take();
      do_cmd(8'h01, 8'hFF, 8'h01, 2'd2, lat);
      checks++;
      if ({bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {8'h00, 3'b011}) begin
         errors++;
         $display("FAIL err_short_add: got data=%h c=%b z=%b e=%b expected data=00 c=0 z=1 e=1",
                  bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
      end
      take();
      do_cmd(8'h00, 8'h77, 8'h88, 2'd1, lat);
      checks++;
      if ({bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {8'h00, 3'b010}) begin
         errors++;
         $display("FAIL nop_cnt1: got data=%h c=%b z=%b e=%b expected data=00 c=0 z=1 e=0",
                  bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
      end
      take();
      do_cmd(8'h00, 8'h00, 8'h00, 2'd0, lat);
      checks++;
      if (bus.out_err !== 1'b1) begin
         errors++;
         $display("FAIL nop_cnt0: got err=%b expected 1", bus.out_err);
      end
      take();
      checks++;
      if (bus.cmd_count !== 16'd15) begin
         errors++;
         $display("FAIL err_count: got %0d expected 15", bus.cmd_count);
      end
   endtask

   task automatic test_mul();
      int lat;
`ifdef CMD_EXEC_MUL_EN
      do_cmd(8'h08, 8'h13, 8'h11, 2'd3, lat);
      checks++;
      if (lat !== 9 || {bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {8'h43, 3'b100}) begin
         errors++;
         $display("FAIL mul_13x11: got lat=%0d data=%h c=%b z=%b e=%b expected lat=9 data=43 c=1 z=0 e=0",
                  lat, bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
      end
      take();
      do_cmd(8'h08, 8'h0F, 8'h0F, 2'd3, lat);
      checks++;
      if (lat !== 9 || {bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {8'hE1, 3'b000}) begin
         errors++;
         $display("FAIL mul_0fx0f: got lat=%0d data=%h c=%b z=%b e=%b expected lat=9 data=e1 c=0 z=0 e=0",
                  lat, bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
      end
      take();
`else
      do_cmd(8'h08, 8'h13, 8'h11, 2'd3, lat);
      checks++;
      if (lat !== 1 || {bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {8'h00, 3'b011}) begin
         errors++;
         $display("FAIL mul_disabled: got lat=%0d data=%h c=%b z=%b e=%b expected lat=1 data=00 c=0 z=1 e=1",
                  lat, bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
      end
      take();
      do_cmd(8'h08, 8'h0F, 8'h0F, 2'd3, lat);
      checks++;
      if (lat !== 1 || bus.out_err !== 1'b1) begin
         errors++;
         $display("FAIL mul_disabled2: got lat=%0d err=%b expected lat=1 err=1", lat, bus.out_err);
      end
      take();
`endif
      checks++;
      if (bus.cmd_count !== 16'd17) begin
         errors++;
         $display("FAIL mul_count: got %0d expected 17", bus.cmd_count);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bus.out_ready = 1'b1;
      do_cmd(8'h04, 8'h01, 8'h02, 2'd3, lat);
      checks++;
      if (lat !== 1 || bus.out_data !== 8'h03) begin
         errors++;
         $display("FAIL early_ready_result: got lat=%0d data=%h expected lat=1 data=03", lat, bus.out_data);
      end
      // out_ready already high: the handshake completes on the first out_valid edge.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.cmd_count} !== {1'b0, 1'b1, 16'd18}) begin
         errors++;
         $display("FAIL early_ready_handshake: got vld=%b rdy=%b count=%0d expected vld=0 rdy=1 count=18",
                  bus.out_valid, bus.in_ready, bus.cmd_count);
      end
      do_cmd(8'h01, 8'h7F, 8'h01, 2'd3, lat);
      checks++;
      if (lat !== 1 || {bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {8'h80, 3'b000}) begin
         errors++;
         $display("FAIL back_to_back: got lat=%0d data=%h c=%b expected lat=1 data=80 c=0",
                  lat, bus.out_data, bus.out_carry);
      end
      take();
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      bus.in_valid = 1'b1;
`ifdef CMD_EXEC_MUL_EN
      bus.in_op = 8'h08;
`else
      bus.in_op = 8'h01;
`endif
      bus.in_a   = 8'h13;
      bus.in_b   = 8'h11;
      bus.in_cnt = 2'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.cmd_count} !== {1'b0, 1'b1, 16'd0}) begin
         errors++;
         $display("FAIL mid_reset_state: got vld=%b rdy=%b count=%0d expected vld=0 rdy=1 count=0",
                  bus.out_valid, bus.in_ready, bus.cmd_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0 || bus.cmd_count !== 16'd0)
            seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL mid_reset_discard: got %0d cycles with result/count activity expected 0", seen);
      end
      do_cmd(8'h01, 8'h01, 8'h01, 2'd3, lat);
      checks++;
      if (lat !== 1 || bus.out_data !== 8'h02 || bus.out_err !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_add: got lat=%0d data=%h err=%b expected lat=1 data=02 err=0",
                  lat, bus.out_data, bus.out_err);
      end
      take();
      checks++;
      if (bus.cmd_count !== 16'd1) begin
         errors++;
         $display("FAIL post_reset_count: got %0d expected 1", bus.cmd_count);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 8'h00;
      bus.in_a      = 8'h00;
      bus.in_b      = 8'h00;
      bus.in_cnt    = 2'd0;
      bus.out_ready = 1'b0;
      test_reset();
      test_add();
      test_sub_backpressure();
      test_alu_ops();
      test_errors();
      test_mul();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmd_exec.md
# cmd_exec

Downstream stage of the operand accumulator: accepts one command bundle (opcode byte plus up to two operand bytes) over a valid/ready handshake, executes it, and presents an 8-bit result with status flags over a second valid/ready handshake. Single-cycle ALU ops complete in one cycle. MUL runs as an iterative shift-add over DATA_W cycles. The block also keeps a saturating count of completed commands for debug readback.

## Interface
- DATA_W, 8, operand/result width; MUL iteration count equals DATA_W
- CNT_W, 16, width of completed-command counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  bundle present
- in_ready  out  1  block can accept bundle
- in_op  in  8  opcode byte (accumulator slot 0)
- in_a  in  DATA_W  operand A (slot 1)
- in_b  in  DATA_W  operand B (slot 2)
- in_cnt  in  2  number of valid slots in bundle, 0..3
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_data  out  DATA_W  result
- out_zero  out  1  out_data == 0
- out_carry  out  1  carry/borrow/overflow (op-specific)
- out_err  out  1  illegal opcode or too few operands
- cmd_count  out  CNT_W  completed commands, saturating

## Operation
- Opcodes: 0x00 NOP (result 0, needs cnt>=1); 0x01 ADD, 0x02 SUB (A-B, carry=borrow), 0x03 AND, 0x04 OR, 0x05 XOR, 0x06 SHL A by B[2:0] (carry = last bit shifted out, 0 if shift is 0), 0x07 SHR likewise, 0x08 MUL (low byte result, carry = high byte nonzero); all need cnt==3.
- Any other opcode, or cnt below requirement: out_err=1, out_data=0, out_carry=0, out_zero=1; still a completed command.
- Arithmetic is modulo 2^DATA_W; ADD carry = bit DATA_W of the (DATA_W+1)-bit sum.
- States: IDLE (in_ready=1) -> accept on in_valid: MUL-legal goes to MUL, else computes and goes to DONE. MUL iterates DATA_W cycles then goes to DONE. DONE holds out_valid=1 with stable outputs until out_ready, then goes to IDLE.
- Operands are registered at acceptance. Input changes after acceptance have no effect.
- cmd_count increments on each out_valid&&out_ready. It holds at 2^CNT_W-1.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_zero=0, out_carry=0, out_err=0, cmd_count=0.
- Reset asserted mid-MUL or in DONE: result is discarded immediately, with no counter increment.

## Timing
- in_ready is 1 only in IDLE, so at most one command is in flight. No bypass from DONE to accept.
- Single-cycle op accepted at edge N: out_valid=1 after edge N+1.
- MUL accepted at edge N: out_valid=1 after edge N+1+DATA_W (N+9 at default).
- out_valid&&out_ready at edge M: out_valid=0 and in_ready=1 after M. The next bundle can be accepted at M+1 at the earliest.
- out_ready held high before out_valid: handshake completes on the first out_valid cycle.
- out_ready is ignored when out_valid=0.

## Configuration
- CMD_EXEC_MUL_EN defined: opcode 0x08 is legal and executes as specified.
- CMD_EXEC_MUL_EN undefined: no multiplier logic, no MUL state. Opcode 0x08 returns the error response with single-cycle latency.

## Structure
- Shared package cmd_pkg: opcode enum, FSM state enum, required-operand-count constants, packed result struct {data, zero, carry, err}.
- One sub-module, cmd_mul_seq: iterative shift-add multiplier with start/busy/done, DATA_W-cycle latency, instantiated only under CMD_EXEC_MUL_EN.

## Test plan
- Reset check: assert rst_n=0 -> all outputs at reset values. Release -> in_ready=1.
- ADD: op=0x01, A=0xF0, B=0x20, cnt=3 -> one cycle later out_data=0x10, carry=1, zero=0, err=0. cmd_count=1 after handshake.
- SUB with backpressure: op=0x02, A=0x05, B=0x05, out_ready=0 for 4 cycles -> out_data=0x00, zero=1, carry=0, held stable. in_ready=0 until handshake.
- MUL (macro on): op=0x08, A=0x13, B=0x11 -> out_data=0x43, carry=1, out_valid exactly 9 cycles after accept. Macro off -> err=1 after 1 cycle.
- Errors: op=0x3F cnt=3 -> err=1, data=0. op=0x01 cnt=2 -> err=1. NOP cnt=1 -> data=0, err=0.
- Reset mid-MUL: drop rst_n at cycle 4 of MUL -> out_valid never rises, cmd_count unchanged. Next ADD 0x01+0x01 -> 0x02.
